// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer around a shared AES-256 block core: counter issue, XOR, stream out.
// Optional macro AES_CTR_WRAP_ERR_EN: abort job with sticky err on counter wrap.
module aes_ctr_sequencer #(
    parameter int KEY_W = 256,
    parameter int BLK_W = 128,
    parameter int CTR_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic [CNT_W-1:0] cfg_nblocks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_block,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_result,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, XOR, OUT
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] ctr_q, ctr_d;
    logic [BLK_W-1:0] ks_q, ks_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BLK_W-1:0] odata_q, odata_d;
    logic             ovalid_q, ovalid_d;
    logic             olast_q, olast_d;
    logic             last_blk;

    assign last_blk = (rem_q == CNT_W'(1));

`ifdef AES_CTR_WRAP_ERR_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            ctr_q    <= '0;
            ks_q     <= '0;
            rem_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            ctr_q    <= ctr_d;
            ks_q     <= ks_d;
            rem_q    <= rem_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

`ifdef AES_CTR_WRAP_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        ks_d       = ks_q;
        rem_d      = rem_q;
        odata_d    = odata_q;
        ovalid_d   = ovalid_q;
        olast_d    = olast_q;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        core_start = 1'b0;
`ifdef AES_CTR_WRAP_ERR_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                // zero-length jobs complete the handshake but latch nothing
                if (cfg_valid && cfg_nblocks != '0) begin
                    key_d   = cfg_key;
                    ctr_d   = cfg_iv;
                    rem_d   = cfg_nblocks;
                    state_d = REQ;
`ifdef AES_CTR_WRAP_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            REQ: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    ks_d    = core_result;
                    state_d = XOR;
                end
            end
            XOR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    odata_d  = in_data ^ ks_q;
                    ovalid_d = 1'b1;
                    olast_d  = last_blk;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    olast_d  = 1'b0;
                    rem_d    = rem_q - CNT_W'(1);
                    ctr_d    = {ctr_q[BLK_W-1:CTR_W],
                                ctr_q[CTR_W-1:0] + CTR_W'(1)};
                    state_d  = last_blk ? IDLE : REQ;
`ifdef AES_CTR_WRAP_ERR_EN
                    // refuse to reuse a counter value within one job
                    if (&ctr_q[CTR_W-1:0] && !last_blk) begin
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid  = ovalid_q;
    assign out_data   = odata_q;
    assign out_last   = olast_q;
    assign core_key   = key_q;
    assign core_block = ctr_q;
    assign busy       = (state_q != IDLE);

endmodule
